btn_irq_sequencer: RTL and testbench
====================================

Name: btn_irq_sequencer

Overview:
Avalon-MM master that services the button PIO slave of the vending machine. After reset it programs the PIO interrupt mask. On each PIO irq it reads and clears the edge-capture register. It then delivers each captured button press to the vending FSM as a one-hot event over a valid/ready handshake, lowest bit first. This removes per-press CPU involvement for button handling.

Parameters:
WIDTH, 3, number of button bits (matches PIO data width)
MASK_INIT, 3'b111, irq_mask value written to the PIO after reset

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pio_address  out  2  PIO register address (0 data, 2 irq_mask, 3 edge_capture)
pio_chipselect  out  1  PIO chipselect
pio_write_n  out  1  PIO write strobe, active low
pio_writedata  out  WIDTH  PIO write data
pio_readdata  in  WIDTH  PIO read data; registered, valid 1 cycle after address is presented
pio_irq  in  1  PIO interrupt, level
mask_in  in  WIDTH  new irq_mask value
mask_wr  in  1  1-cycle pulse: load mask_in and reprogram the PIO
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_onehot  out  WIDTH  one-hot button id
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values:
  - State = MASK_WR; mask_reg = MASK_INIT; mask_pend = 0; pend = 0.
  - pio_address = 0, pio_chipselect = 0, pio_write_n = 1, pio_writedata = 0.
  - evt_valid = 0, evt_onehot = 0, busy = 1.
- Interface timing: all PIO outputs are registered, decoded from the state register. Default outputs in any state not listed below are address 0, chipselect 0, write_n 1.
- States and transitions:
  - MASK_WR: address 2, chipselect 1, write_n 0, writedata = mask_reg. Lasts 1 cycle; clears mask_pend; -> IDLE.
  - IDLE: if mask_pend -> MASK_WR. Otherwise, if pio_irq -> RD_ADDR. mask_pend has priority over irq.
  - RD_ADDR: address 3, chipselect 1, write_n 1. -> RD_CAP.
  - RD_CAP: address held at 3, chipselect 0. Captures pend <= pio_readdata & mask_reg. -> CLR.
  - CLR: address 3, chipselect 1, write_n 0, writedata all ones. -> EMIT if pend != 0, else IDLE.
  - EMIT:
    - evt_valid = 1; evt_onehot = lowest set bit of pend.
    - On evt_valid & evt_ready, that bit is cleared from pend.
    - If it was the last set bit, evt_valid drops the next cycle and state -> IDLE. Otherwise the next event is presented the next cycle, with no bubble.
- Handshake:
  - evt_onehot and evt_valid hold stable while evt_ready = 0.
  - evt_onehot is exactly one-hot whenever evt_valid = 1.
- Latency: irq sampled in IDLE -> first evt_valid 4 cycles later (RD_ADDR, RD_CAP, CLR, EMIT).
- mask_wr:
  - Accepted in any state: mask_reg <= mask_in and mask_pend <= 1 on the same cycle.
  - Serviced at the next IDLE.
  - A pend already captured is not re-filtered.
  - Back-to-back mask_wr pulses: the last value wins; only one MASK_WR cycle is issued.
- irq while not IDLE: ignored. The PIO holds edge_capture, so the irq is serviced on return to IDLE.
- Edge loss: an edge the PIO detects between the RD_CAP sample and the CLR write is lost. This is accepted behaviour (press rate is far below 3 cycles).
- pio_readdata bits outside mask_reg are discarded; they are still cleared by CLR.
- Reset asserted mid-transaction: all outputs go to reset values immediately; pend is discarded; the sequence restarts with MASK_WR using MASK_INIT.

Optional Feature:
BTN_SEQ_LEVEL_CHECK_EN
- Defined:
  - Two extra states, LVL_ADDR and LVL_CAP, are inserted between CLR and EMIT.
  - LVL_ADDR: address 0, chipselect 1, read. LVL_CAP: pend <= pend & pio_readdata.
  - Effect: only buttons still held high are reported (glitch rejection).
  - If pend becomes 0 -> IDLE.
  - Latency grows to 6 cycles.
- Undefined: CLR goes directly to EMIT/IDLE as described above.

Test Plan:
- Reset release -> next cycle: address 2, chipselect 1, write_n 0, writedata 3'b111 for exactly 1 cycle; then busy 0, evt_valid 0.
- PIO bit1 rising edge, evt_ready tied 1 -> read of addr 3, write addr 3 with 3'b111, exactly one event evt_onehot 3'b010; edge_capture reads 0 afterwards; busy returns 0.
- Bits 0 and 2 rise the same cycle, evt_ready low for 5 cycles then high -> evt_onehot 3'b001 held stable for 5 cycles, then 3'b100 on the following cycle, then evt_valid 0.
- mask_wr with mask_in 3'b001 during EMIT -> no PIO write until IDLE; then 1-cycle write addr 2, data 3'b001; a later bit2 press yields no irq and no event.
- reset_n low for 2 cycles during EMIT -> evt_valid 0 immediately; after release the MASK_WR of 3'b111 is repeated; no stale event appears.
- With BTN_SEQ_LEVEL_CHECK_EN defined: bit0 pulse 1 cycle wide plus bit1 held -> address 0 read after CLR; only 3'b010 is emitted.

Source files
------------

// File: rtl/btn_irq_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btn_irq_sequencer
//
// Avalon-MM master for the vending machine's button PIO. After reset it writes
// the PIO irq_mask. On each PIO irq it reads edge_capture, clears it by writing
// all ones, and then hands each captured press to the vending FSM as a one-hot
// event, lowest bit first, over a valid/ready handshake.
//
// Optional feature (compile-time macro BTN_SEQ_LEVEL_CHECK_EN):
//   After the clear write, the PIO data register is read and only buttons that
//   are still held high are reported. This rejects glitches. Irq-to-event
//   latency becomes 6 cycles instead of 4.
//
// Ports:
//   clk, reset_n     clock; asynchronous active-low reset
//   pio_address      PIO register address (0 data, 2 irq_mask, 3 edge_capture)
//   pio_chipselect   PIO chipselect
//   pio_write_n      PIO write strobe, active low
//   pio_writedata    PIO write data
//   pio_readdata     PIO read data, valid one cycle after the address
//   pio_irq          PIO interrupt (level)
//   mask_in, mask_wr new irq_mask value and a 1-cycle load strobe
//   evt_valid        an event is presented
//   evt_ready        the consumer accepts the event
//   evt_onehot       one-hot button id
//   busy             high whenever the sequencer is not idle
//
// Handshake: an event transfers on a rising clk edge where evt_valid and
// evt_ready are both high. While evt_ready is low, evt_valid and evt_onehot
// hold. evt_onehot is exactly one-hot whenever evt_valid is high.
// -----------------------------------------------------------------------------
module btn_irq_sequencer #(
    parameter int                WIDTH     = 3,
    parameter logic [WIDTH-1:0]  MASK_INIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [WIDTH-1:0] pio_writedata,
    input  logic [WIDTH-1:0] pio_readdata,
    input  logic             pio_irq,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             mask_wr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_onehot,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_MASK_WR  = 3'd0,
        S_IDLE     = 3'd1,
        S_RD_ADDR  = 3'd2,
        S_RD_CAP   = 3'd3,
        S_CLR      = 3'd4,
        S_LVL_ADDR = 3'd5,
        S_LVL_CAP  = 3'd6,
        S_EMIT     = 3'd7
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] mask_reg;
    logic             mask_pend;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_nx;

    // Outputs decoded from the next state, so the bus matches the state the
    // FSM is in for the whole cycle.
    logic [1:0]       addr_nx;
    logic             cs_nx;
    logic             wn_nx;
    logic [WIDTH-1:0] wd_nx;

    function automatic logic [WIDTH-1:0] lowest_bit(input logic [WIDTH-1:0] v);
        return v & (~v + ONE);
    endfunction

    // Next-state logic
    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        case (state)
            // The MASK_WR state is entered from reset before the write is on
            // the bus. Leave only once the write has been driven for a cycle.
            S_MASK_WR: if (!pio_write_n) state_nx = S_IDLE;
            S_IDLE: begin
                if (mask_pend)    state_nx = S_MASK_WR;
                else if (pio_irq) state_nx = S_RD_ADDR;
            end
            S_RD_ADDR: state_nx = S_RD_CAP;
            S_RD_CAP: begin
                pend_nx  = pio_readdata & mask_reg;
                state_nx = S_CLR;
            end
`ifdef BTN_SEQ_LEVEL_CHECK_EN
            S_CLR: state_nx = (pend != '0) ? S_LVL_ADDR : S_IDLE;
            S_LVL_ADDR: state_nx = S_LVL_CAP;
            S_LVL_CAP: begin
                pend_nx  = pend & pio_readdata;
                state_nx = (pend_nx != '0) ? S_EMIT : S_IDLE;
            end
`else
            S_CLR: state_nx = (pend != '0) ? S_EMIT : S_IDLE;
`endif
            S_EMIT: begin
                if (evt_ready) begin
                    pend_nx = pend & ~evt_onehot;
                    if (pend_nx == '0) state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus decode of the next state
    always_comb begin
        addr_nx = 2'd0;
        cs_nx   = 1'b0;
        wn_nx   = 1'b1;
        wd_nx   = '0;
        case (state_nx)
            S_MASK_WR: begin
                addr_nx = 2'd2;
                cs_nx   = 1'b1;
                wn_nx   = 1'b0;
                // A mask_wr arriving on this very edge is written directly,
                // so back-to-back strobes produce a single write.
                wd_nx   = mask_wr ? mask_in : mask_reg;
            end
            S_RD_ADDR: begin
                addr_nx = 2'd3;
                cs_nx   = 1'b1;
            end
            S_RD_CAP: addr_nx = 2'd3;
            S_CLR: begin
                addr_nx = 2'd3;
                cs_nx   = 1'b1;
                wn_nx   = 1'b0;
                wd_nx   = '1;
            end
            S_LVL_ADDR: cs_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_MASK_WR;
            mask_reg       <= MASK_INIT;
            mask_pend      <= 1'b0;
            pend           <= '0;
            pio_address    <= 2'd0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            evt_valid      <= 1'b0;
            evt_onehot     <= '0;
            busy           <= 1'b1;
        end else begin
            state          <= state_nx;
            pend           <= pend_nx;
            pio_address    <= addr_nx;
            pio_chipselect <= cs_nx;
            pio_write_n    <= wn_nx;
            pio_writedata  <= wd_nx;
            evt_valid      <= (state_nx == S_EMIT);
            evt_onehot     <= (state_nx == S_EMIT) ? lowest_bit(pend_nx) : '0;
            busy           <= (state_nx != S_IDLE);
            if (mask_wr) mask_reg <= mask_in;
            // Issuing the write consumes any pending request, including one
            // raised on this same edge (its value is what gets written).
            if (state_nx == S_MASK_WR) mask_pend <= 1'b0;
            else if (mask_wr)          mask_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_btn_irq_sequencer.sv
`timescale 1ns/1ps
// Bench for btn_irq_sequencer: behavioural button PIO model, event scoreboard,
// one task per scenario.
module tb_btn_irq_sequencer;
  localparam int W = 3;
`ifdef BTN_SEQ_LEVEL_CHECK_EN
  localparam int LAT = 6;
  localparam int RD0_PER_IRQ = 1;
`else
  localparam int LAT = 4;
  localparam int RD0_PER_IRQ = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   pio_address;
  logic         pio_chipselect;
  logic         pio_write_n;
  logic [W-1:0] pio_writedata;
  logic [W-1:0] pio_readdata = '0;
  logic         pio_irq;
  logic [W-1:0] mask_in = '0;
  logic         mask_wr = 1'b0;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [W-1:0] evt_onehot;
  logic         busy;

  btn_irq_sequencer #(.WIDTH(W), .MASK_INIT(3'b111)) dut (
    .clk(clk), .reset_n(reset_n),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .mask_in(mask_in), .mask_wr(mask_wr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_onehot(evt_onehot),
    .busy(busy)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  int evt_cnt = 0;

  // ---------------- button PIO model ----------------
  logic [W-1:0] btn = '0;
  logic [W-1:0] btn_d = '0;
  logic [W-1:0] edge_cap = '0;
  logic [W-1:0] irq_mask = '0;
  logic [W-1:0] clr_bits;
  int rd0_cnt = 0, rd3_cnt = 0, wr2_cnt = 0, wr3_cnt = 0;
  logic [W-1:0] wr2_last = '0, wr3_last = '0;

  assign pio_irq = |(edge_cap & irq_mask);

  always @(posedge clk) begin
    btn_d <= btn;
    clr_bits = '0;
    if (pio_chipselect && pio_write_n) begin
      case (pio_address)
        2'd0: begin pio_readdata <= btn; rd0_cnt++; end
        2'd2: pio_readdata <= irq_mask;
        2'd3: begin pio_readdata <= edge_cap; rd3_cnt++; end
        default: pio_readdata <= '0;
      endcase
    end
    if (pio_chipselect && !pio_write_n) begin
      if (pio_address == 2'd2) begin
        irq_mask <= pio_writedata; wr2_cnt++; wr2_last = pio_writedata;
      end
      if (pio_address == 2'd3) begin
        clr_bits = pio_writedata; wr3_cnt++; wr3_last = pio_writedata;
      end
    end
    edge_cap <= (edge_cap & ~clr_bits) | (btn & ~btn_d);
  end

  // ---------------- event monitor / scoreboard ----------------
  logic hold_prev = 1'b0;
  logic [W-1:0] hold_oh = '0;
  logic [W-1:0] exp_oh;

  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_prev) begin
        tests_run++;
        if (evt_valid !== 1'b1 || evt_onehot !== hold_oh) begin
          tests_failed++;
          $display("FAIL evt_hold: valid=%b onehot=%b, required valid=1 onehot=%b",
                   evt_valid, evt_onehot, hold_oh);
        end
      end
      if (evt_valid === 1'b1) begin
        tests_run++;
        if (!$onehot(evt_onehot)) begin
          tests_failed++;
          $display("FAIL evt_onehot_shape: onehot=%b, required exactly one bit", evt_onehot);
        end
      end
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        tests_run++;
        evt_cnt++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL evt_unexpected: onehot=%b, required no event", evt_onehot);
        end else begin
          exp_oh = exp_q.pop_front();
          if (evt_onehot !== exp_oh) begin
            tests_failed++;
            $display("FAIL evt_data: onehot=%b, required %b", evt_onehot, exp_oh);
          end
        end
      end
    end
    hold_prev = reset_n && evt_valid && !evt_ready;
    hold_oh = evt_onehot;
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({pio_address, pio_chipselect, pio_write_n, pio_writedata} !== {2'd0, 1'b0, 1'b1, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%0d cs=%b wn=%b wd=%b, required 0 0 1 000",
               pio_address, pio_chipselect, pio_write_n, pio_writedata);
    end
    tests_run++;
    if ({evt_valid, evt_onehot, busy} !== {1'b0, 3'b000, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_evt: valid=%b onehot=%b busy=%b, required 0 000 1",
               evt_valid, evt_onehot, busy);
    end
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++;
    if ({pio_address, pio_chipselect, pio_write_n, pio_writedata} !== {2'd2, 1'b1, 1'b0, 3'b111}) begin
      tests_failed++;
      $display("FAIL reset_mask_wr: addr=%0d cs=%b wn=%b wd=%b, required 2 1 0 111",
               pio_address, pio_chipselect, pio_write_n, pio_writedata);
    end
    @(negedge clk);
    tests_run++;
    if ({pio_chipselect, pio_write_n, busy, evt_valid} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_idle: cs=%b wn=%b busy=%b valid=%b, required 0 1 0 0",
               pio_chipselect, pio_write_n, busy, evt_valid);
    end
    tests_run++;
    if (wr2_cnt !== 1 || irq_mask !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_mask_count: writes=%0d mask=%b, required 1 111", wr2_cnt, irq_mask);
    end
  endtask

  task automatic test_single_press();
    int rd3_b = rd3_cnt, wr3_b = wr3_cnt, rd0_b = rd0_cnt, evt_b = evt_cnt;
    int n = 0;
    evt_ready = 1'b1;
    exp_q.push_back(3'b010);
    @(posedge clk); #2 btn = 3'b010;
    while (!pio_irq && n < 10) begin @(negedge clk); n++; end
    tests_run++;
    if (!pio_irq) begin
      tests_failed++;
      $display("FAIL single_irq: irq=%b after %0d cycles, required 1", pio_irq, n);
    end
    n = 0;
    while (!evt_valid && n < 20) begin @(negedge clk); n++; end
    tests_run++;
    if (n !== LAT) begin
      tests_failed++;
      $display("FAIL single_latency: %0d cycles, required %0d", n, LAT);
    end
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 20) begin @(negedge clk); n++; end
    tests_run++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL single_done: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
    tests_run++;
    if (rd3_cnt - rd3_b !== 1 || wr3_cnt - wr3_b !== 1 || wr3_last !== 3'b111) begin
      tests_failed++;
      $display("FAIL single_bus: reads3=%0d writes3=%0d wdata=%b, required 1 1 111",
               rd3_cnt - rd3_b, wr3_cnt - wr3_b, wr3_last);
    end
    tests_run++;
    if (rd0_cnt - rd0_b !== RD0_PER_IRQ || evt_cnt - evt_b !== 1 || edge_cap !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_counts: reads0=%0d events=%0d edge_cap=%b, required %0d 1 000",
               rd0_cnt - rd0_b, evt_cnt - evt_b, edge_cap, RD0_PER_IRQ);
    end
    @(posedge clk); #2 btn = 3'b000;
  endtask

  task automatic test_back_to_back_events();
    int n = 0;
    evt_ready = 1'b0;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    @(posedge clk); #2 btn = 3'b101;
    while (!evt_valid && n < 30) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (evt_valid !== 1'b1 || evt_onehot !== 3'b001) begin
        tests_failed++;
        $display("FAIL b2b_stall%0d: valid=%b onehot=%b, required 1 001", i, evt_valid, evt_onehot);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #2 evt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_onehot !== 3'b100) begin
      tests_failed++;
      $display("FAIL b2b_second: valid=%b onehot=%b, required 1 100", evt_valid, evt_onehot);
    end
    @(negedge clk);
    tests_run++;
    if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_end: valid=%b pending=%0d, required 0 0", evt_valid, exp_q.size());
    end
    @(posedge clk); #2 btn = 3'b000;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_mask_wr();
    int wr2_b = wr2_cnt;
    int evt_b;
    int n = 0;
    evt_ready = 1'b0;
    exp_q.push_back(3'b001);
    @(posedge clk); #2 btn = 3'b001;
    while (!evt_valid && n < 30) begin @(negedge clk); n++; end
    @(posedge clk); #2 mask_in = 3'b001; mask_wr = 1'b1;
    @(posedge clk); #2 mask_wr = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (wr2_cnt - wr2_b !== 0 || busy !== 1'b1 || evt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_defer: writes=%0d busy=%b valid=%b, required 0 1 1",
               wr2_cnt - wr2_b, busy, evt_valid);
    end
    @(posedge clk); #2 evt_ready = 1'b1;
    n = 0;
    while (wr2_cnt == wr2_b && n < 10) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    tests_run++;
    if (wr2_cnt - wr2_b !== 1 || wr2_last !== 3'b001 || irq_mask !== 3'b001) begin
      tests_failed++;
      $display("FAIL mask_write: writes=%0d wdata=%b pio_mask=%b, required 1 001 001",
               wr2_cnt - wr2_b, wr2_last, irq_mask);
    end
    evt_b = evt_cnt;
    @(posedge clk); #2 btn = 3'b100;
    repeat (15) @(negedge clk);
    tests_run++;
    if (pio_irq !== 1'b0 || busy !== 1'b0 || evt_cnt - evt_b !== 0) begin
      tests_failed++;
      $display("FAIL mask_filter: irq=%b busy=%b events=%0d, required 0 0 0",
               pio_irq, busy, evt_cnt - evt_b);
    end
    // Back-to-back strobes: only the last value (111) is written, once. The
    // still-captured bit2 press then surfaces.
    wr2_b = wr2_cnt;
    exp_q.push_back(3'b100);
    @(posedge clk); #2 mask_in = 3'b010; mask_wr = 1'b1;
    @(posedge clk); #2 mask_in = 3'b111;
    @(posedge clk); #2 mask_wr = 1'b0;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 30) begin @(negedge clk); n++; end
    tests_run++;
    if (wr2_cnt - wr2_b !== 1 || wr2_last !== 3'b111 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL mask_b2b: writes=%0d wdata=%b pending=%0d, required 1 111 0",
               wr2_cnt - wr2_b, wr2_last, exp_q.size());
    end
    @(posedge clk); #2 btn = 3'b000;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_during_emit();
    int evt_b;
    int wr2_b;
    int n = 0;
    evt_ready = 1'b0;
    @(posedge clk); #2 btn = 3'b010;
    while (!evt_valid && n < 30) begin @(negedge clk); n++; end
    evt_b = evt_cnt;
    wr2_b = wr2_cnt;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({evt_valid, busy, pio_chipselect, pio_write_n} !== {1'b0, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_async: valid=%b busy=%b cs=%b wn=%b, required 0 1 0 1",
               evt_valid, busy, pio_chipselect, pio_write_n);
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1; btn = 3'b000;
    @(posedge clk); @(negedge clk);
    tests_run++;
    if ({pio_address, pio_chipselect, pio_write_n, pio_writedata} !== {2'd2, 1'b1, 1'b0, 3'b111}) begin
      tests_failed++;
      $display("FAIL rst_mask_wr: addr=%0d cs=%b wn=%b wd=%b, required 2 1 0 111",
               pio_address, pio_chipselect, pio_write_n, pio_writedata);
    end
    @(posedge clk); #2 evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (evt_cnt - evt_b !== 0 || busy !== 1'b0 || wr2_cnt - wr2_b !== 1) begin
      tests_failed++;
      $display("FAIL rst_no_stale: events=%0d busy=%b mask_writes=%0d, required 0 0 1",
               evt_cnt - evt_b, busy, wr2_cnt - wr2_b);
    end
  endtask

`ifdef BTN_SEQ_LEVEL_CHECK_EN
  task automatic test_level_check();
    int rd0_b = rd0_cnt, evt_b = evt_cnt;
    int n = 0;
    evt_ready = 1'b1;
    exp_q.push_back(3'b010);
    @(posedge clk); #2 btn = 3'b011;
    @(posedge clk); #2 btn = 3'b010;
    while ((busy || exp_q.size() != 0 || n < 3) && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (rd0_cnt - rd0_b !== 1 || evt_cnt - evt_b !== 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL level_check: reads0=%0d events=%0d pending=%0d, required 1 1 0",
               rd0_cnt - rd0_b, evt_cnt - evt_b, exp_q.size());
    end
    @(posedge clk); #2 btn = 3'b000;
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_back_to_back_events();
    test_mask_wr();
    test_reset_during_emit();
`ifdef BTN_SEQ_LEVEL_CHECK_EN
    test_level_check();
`endif
    repeat (5) @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue: %0d events still expected, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
